key_schedule_gen: RTL and testbench
===================================

# key_schedule_gen

Parametrised, iterative AES key-schedule generator supporting AES-128/192/256, selected at run time per request. It computes one 32-bit schedule word per clock with a single 4-byte S-box datapath and holds the full schedule in an internal word store. The cipher round pipeline reads any round key through a registered port. It replaces the fixed AES-128, all-rounds-in-parallel key expansion with a start/busy/done handshake and a much smaller S-box footprint.

## Interface
- `MAX_KEY_BITS`, default 256: largest supported key, one of 128/192/256. Word store depth is 4·(Nr_max+1), i.e. 44/52/60 words. A `key_len` above this limit is rejected.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request expansion. Sampled only in IDLE.
- `key_len`  in  2  00=128, 01=192, 10=256, 11=reserved
- `key`  in  256  cipher key, left-aligned. w0 = `key[255:224]`. Unused low bits are ignored.
- `busy`  out  1  expansion in progress
- `done`  out  1  one-cycle pulse when the schedule is complete
- `err`  out  1  one-cycle pulse when `start` carries an invalid `key_len`
- `key_valid`  out  1  schedule in store is complete and consistent
- `num_rounds`  out  4  Nr of the last completed schedule (10/12/14)
- `rd_idx`  in  4  round-key index, 0..Nr
- `rd_key`  out  128  round key `rd_idx`, laid out {w[4r], w[4r+1], w[4r+2], w[4r+3]} with w[4r] in [127:96]

## Operation
- FSM states:
  - IDLE: if `start` is high and `key_len` is valid, go to EXPAND. If `start` is high and `key_len` is invalid, pulse `err` and stay in IDLE.
  - EXPAND: after the last word is written, go to IDLE and pulse `done`.
- Accepting `start`:
  - Writes w[0..Nk-1] from `key` in the same edge.
  - Latches Nk (4/6/8) and Nr (10/12/14).
  - Sets `busy`=1, clears `key_valid`, loads word counter i=Nk, phase counter j=0, rcon=8'h01.
- Each EXPAND cycle computes w[i] = w[i-Nk] ^ t, where t is:
  - j==0: SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}; rcon then advances by xtime (GF(2^8) doubling, reduction 8'h1b).
  - Nk==8 and j==4: SubWord(w[i-1]).
  - otherwise: w[i-1].
  - j wraps at Nk-1. No dividers or modulo operators.
- Final word index is 4·(Nr+1)-1. After it is written: `busy`←0, `done`←1 for one cycle, `key_valid`←1, `num_rounds`←Nr.
- `start` is ignored while `busy`. A `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.
- Reads:
  - `rd_key` is updated every cycle from `rd_idx`.
  - `rd_idx` > latched Nr (or > 14) returns 128'h0.
  - Reads during EXPAND return the current store contents, with no guarantee of validity.
- Reset mid-expansion aborts. The store need not be cleared, but `key_valid`=0.
- Reset values: `busy`=0, `done`=0, `err`=0, `key_valid`=0, `num_rounds`=0, `rd_key`=0, FSM=IDLE.

## Timing
- `start` accepted at edge 0 → words Nk..4(Nr+1)-1 written at edges 1..N, where N = 40 (128), 46 (192), 52 (256).
- `done` and `key_valid` are high after edge N. `busy` is high after edges 0..N-1.
- `rd_key` latency is 1 cycle from `rd_idx`.
- `err` is high for the cycle after the rejecting edge.
- Critical path: word-store read mux → S-box → XOR → store write. It holds one S-box stage per cycle.

## Structure
- Shared package `aes_pkg` holds:
  - `key_len` encodings.
  - Nk/Nr constants.
  - the xtime function.
  - the SubWord/RotWord helpers.
- Sub-module: existing `sbox` (combinational, 8-bit in/out), instantiated exactly four times.
- Word store is a 60×32 register array, trimmed by `MAX_KEY_BITS`.

## Test plan
- **FIPS-197 A.1 (AES-128)**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: `done` exactly 40 cycles after `start`; `num_rounds`=10; `rd_idx`=1 → a0fafe1788542cb123a339392a6c7605; `rd_idx`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- **FIPS-197 A.2 (AES-192)**
  - Stimulus: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Response: `done` after 46 cycles; `rd_idx`=12 → e98ba06f448c773c8ecc720401002202.
- **FIPS-197 A.3 (AES-256)**
  - Stimulus: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Response: `done` after 52 cycles; `rd_idx`=2 → 9ba354118e6925afa51a8b5f2067fcde; `rd_idx`=14 → fe4890d1e6188d0b046df344706c631e.
- **Invalid key length**
  - Stimulus: `start` with `key_len`=11.
  - Response: `err` pulses one cycle; `busy` stays 0; `key_valid` and the store are unchanged.
- **Reset mid-operation**
  - Stimulus: `rst` at cycle 20 of an AES-128 run.
  - Response: next cycle `busy`=0, `key_valid`=0, `rd_key`=0, and `done` never pulses. A rerun then reproduces the A.1 vectors.
- **Handshake and bounds**
  - Stimulus: `start` held high through an AES-128 run.
  - Response: restarts are ignored while `busy`, and the run is re-accepted in the `done` cycle. `rd_idx`=11 after AES-128 → 0.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES key-schedule definitions:
//            - key-length encodings and the Nk/Nr constants
//            - the FSM state type
//            - GF(2^8) helpers: xtime, multiply, S-box byte
//            - RotWord / SubWord word helpers
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam logic [1:0] c_KLEN_128  = 2'b00;
    localparam logic [1:0] c_KLEN_192  = 2'b01;
    localparam logic [1:0] c_KLEN_256  = 2'b10;
    localparam logic [1:0] c_KLEN_RSVD = 2'b11;

    localparam logic [3:0] c_NK_128 = 4'd4;
    localparam logic [3:0] c_NK_192 = 4'd6;
    localparam logic [3:0] c_NK_256 = 4'd8;
    localparam logic [3:0] c_NR_128 = 4'd10;
    localparam logic [3:0] c_NR_192 = 4'd12;
    localparam logic [3:0] c_NR_256 = 4'd14;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    // GF(2^8) doubling with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, which maps 0 to 0) followed by
    // the affine transform, instead of a 256-entry table.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        inv  = gf_mul(x127, x127);
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
// Module   : sbox
// Purpose  : Combinational AES forward S-box, one byte.
// Ports    : i_byte [7:0] - input byte
//            o_byte [7:0] - substituted byte
// Revision : 1.0 - initial release
// ============================================================================
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = sbox_byte(i_byte);

endmodule
`default_nettype wire

// File: rtl/key_schedule_gen.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule_gen
// Purpose  : Iterative AES-128/192/256 key expansion, one schedule word per
//            clock through a single 4-byte S-box datapath. The expanded
//            schedule sits in a word store; round keys are read out through a
//            registered port.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_start        - request expansion (sampled in IDLE only)
//            i_key_len[1:0] - 00=128, 01=192, 10=256, 11=reserved
//            i_key[255:0]   - cipher key, left-aligned
//            o_busy         - expansion in progress
//            o_done         - one-cycle pulse on completion
//            o_err          - one-cycle pulse on rejected key length
//            o_key_valid    - store holds a complete schedule
//            o_num_rounds   - Nr of the last completed schedule
//            i_rd_idx[3:0]  - round-key index
//            o_rd_key[127:0]- round key, one cycle after i_rd_idx
// Revision : 1.0 - initial release
// ============================================================================
module key_schedule_gen
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [1:0]   i_key_len,
    input  logic [255:0] i_key,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic         o_key_valid,
    output logic [3:0]   o_num_rounds,
    input  logic [3:0]   i_rd_idx,
    output logic [127:0] o_rd_key
);

    localparam int         c_NR_MAX  = (MAX_KEY_BITS == 128) ? 10 :
                                       (MAX_KEY_BITS == 192) ? 12 : 14;
    localparam int         c_DEPTH   = 4 * (c_NR_MAX + 1);
    localparam logic [1:0] c_LEN_MAX = (MAX_KEY_BITS == 128) ? c_KLEN_128 :
                                       (MAX_KEY_BITS == 192) ? c_KLEN_192 : c_KLEN_256;
    localparam int         c_AW      = 6;

    logic [31:0]     r_w [c_DEPTH];
    state_t          r_state;
    logic [c_AW-1:0] r_i;
    logic [c_AW-1:0] r_last;
    logic [2:0]      r_j;
    logic [7:0]      r_rcon;
    logic [3:0]      r_nk;
    logic [3:0]      r_nr;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_key_valid;
    logic [3:0]      r_num_rounds;
    logic [127:0]    r_rd_key;

    logic            w_len_ok;
    logic            w_accept;
    logic [3:0]      w_nk_dec;
    logic [3:0]      w_nr_dec;
    logic [c_AW-1:0] w_last_dec;
    logic [31:0]     w_prev;
    logic [31:0]     w_old;
    logic [31:0]     w_sbox_in;
    logic [31:0]     w_sbox_out;
    logic [31:0]     w_t;
    logic [31:0]     w_new;
    logic [2:0]      w_j_last;
    logic            w_rd_ok;
    logic [c_AW-1:0] w_rd_base;

    assign w_len_ok = (i_key_len != c_KLEN_RSVD) && (i_key_len <= c_LEN_MAX);
    assign w_accept = (r_state == S_IDLE) && i_start && w_len_ok;

    always_comb begin
        w_nk_dec   = c_NK_128;
        w_nr_dec   = c_NR_128;
        w_last_dec = 6'd43;
        case (i_key_len)
            c_KLEN_192: begin
                w_nk_dec   = c_NK_192;
                w_nr_dec   = c_NR_192;
                w_last_dec = 6'd51;
            end
            c_KLEN_256: begin
                w_nk_dec   = c_NK_256;
                w_nr_dec   = c_NR_256;
                w_last_dec = 6'd59;
            end
            default: ;
        endcase
    end

    // Expansion datapath: w[i] = w[i-Nk] ^ t
    assign w_prev    = r_w[r_i - 6'd1];
    assign w_old     = r_w[r_i - {2'b00, r_nk}];
    assign w_sbox_in = (r_j == 3'd0) ? rot_word(w_prev) : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox u_sbox (
            .i_byte (w_sbox_in[8*g +: 8]),
            .o_byte (w_sbox_out[8*g +: 8])
        );
    end

    always_comb begin
        w_t = w_prev;
        if (r_j == 3'd0)
            w_t = w_sbox_out ^ {r_rcon, 24'h0};
        else if ((r_nk == c_NK_256) && (r_j == 3'd4))
            w_t = w_sbox_out;
    end

    assign w_new    = w_old ^ w_t;
    // Nk=8 wraps 3'(8-1)=7, so the phase counter never needs a fourth bit.
    assign w_j_last = 3'(r_nk - 4'd1);

    assign w_rd_ok   = (i_rd_idx <= r_nr) && (i_rd_idx <= 4'd14);
    assign w_rd_base = {i_rd_idx, 2'b00};

    // Word store: not reset, writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept) begin
                for (int k = 0; k < 8; k++) begin
                    if (4'(k) < w_nk_dec)
                        r_w[k] <= i_key[255 - 32*k -: 32];
                end
            end else if (r_state == S_EXPAND) begin
                r_w[r_i] <= w_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_i          <= '0;
            r_last       <= '0;
            r_j          <= '0;
            r_rcon       <= '0;
            r_nk         <= '0;
            r_nr         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_key_valid  <= 1'b0;
            r_num_rounds <= '0;
            r_rd_key     <= '0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rd_key <= w_rd_ok ? {r_w[w_rd_base],         r_w[w_rd_base + 6'd1],
                                   r_w[w_rd_base + 6'd2],  r_w[w_rd_base + 6'd3]}
                                : 128'h0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_len_ok) begin
                            r_state     <= S_EXPAND;
                            r_nk        <= w_nk_dec;
                            r_nr        <= w_nr_dec;
                            r_last      <= w_last_dec;
                            r_i         <= {2'b00, w_nk_dec};
                            r_j         <= 3'd0;
                            r_rcon      <= 8'h01;
                            r_busy      <= 1'b1;
                            r_key_valid <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_EXPAND: begin
                    if (r_j == 3'd0)
                        r_rcon <= xtime(r_rcon);
                    r_j <= (r_j == w_j_last) ? 3'd0 : r_j + 3'd1;
                    if (r_i == r_last) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_key_valid  <= 1'b1;
                        r_num_rounds <= r_nr;
                    end else begin
                        r_i <= r_i + 6'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_key_valid  = r_key_valid;
    assign o_num_rounds = r_num_rounds;
    assign o_rd_key     = r_rd_key;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_schedule_gen
// Purpose  : Self-checking bench for key_schedule_gen using FIPS-197 vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_schedule_gen;

    logic         clk;
    logic         rst;
    logic         i_start;
    logic [1:0]   i_key_len;
    logic [255:0] i_key;
    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic         o_key_valid;
    logic [3:0]   o_num_rounds;
    logic [3:0]   i_rd_idx;
    logic [127:0] o_rd_key;

    int checks = 0;
    int errors = 0;
    logic [127:0] rd_q[$];

    localparam logic [255:0] c_KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                         128'h0123456789abcdeffedcba9876543210};
    localparam logic [255:0] c_KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                         64'hdeadbeefcafef00d};
    localparam logic [255:0] c_KEY256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_schedule_gen #(.MAX_KEY_BITS(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_key_len    (i_key_len),
        .i_key        (i_key),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_key_valid  (o_key_valid),
        .o_num_rounds (o_num_rounds),
        .i_rd_idx     (i_rd_idx),
        .o_rd_key     (o_rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns just after the accepting edge.
    task automatic do_start(input logic [1:0] len, input logic [255:0] key);
        i_key_len = len;
        i_key     = key;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
    endtask

    // Cycles until done is seen (0 on timeout).
    task automatic wait_done(input int limit, output int cnt);
        int c;
        c   = 0;
        cnt = 0;
        while (c < limit && cnt == 0) begin
            tick();
            c++;
            if (o_done) cnt = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b0; i_key_len = 2'b00; i_key = '0; i_rd_idx = 4'd0;
        tick(); tick(); tick();
        checks++;
        if ({o_busy, o_done, o_err, o_key_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {o_busy, o_done, o_err, o_key_valid});
        end
        checks++;
        if (o_num_rounds !== 4'd0) begin
            errors++;
            $display("FAIL reset_num_rounds: got %0d expected 0", o_num_rounds);
        end
        checks++;
        if (o_rd_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_rd_key: got %h expected 0", o_rd_key);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_aes128();
        int cnt;
        logic [3:0]   idx [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
        logic [127:0] exp [4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                                  128'ha0fafe1788542cb123a339392a6c7605,
                                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                                  128'h0};
        logic [127:0] e;
        do_start(2'b00, c_KEY128);
        checks++;
        if (o_busy !== 1'b1 || o_key_valid !== 1'b0) begin
            errors++;
            $display("FAIL a1_busy_after_start: got busy=%b kv=%b expected busy=1 kv=0", o_busy, o_key_valid);
        end
        wait_done(100, cnt);
        checks++;
        if (cnt !== 40) begin
            errors++;
            $display("FAIL a1_done_latency: got %0d expected 40", cnt);
        end
        checks++;
        if (o_busy !== 1'b0 || o_key_valid !== 1'b1 || o_num_rounds !== 4'd10) begin
            errors++;
            $display("FAIL a1_complete: got busy=%b kv=%b nr=%0d expected 0 1 10", o_busy, o_key_valid, o_num_rounds);
        end
        tick();
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL a1_done_pulse: got %b expected 0", o_done);
        end
        for (int k = 0; k < 4; k++) begin
            i_rd_idx = idx[k];
            rd_q.push_back(exp[k]);
            tick();
            e = rd_q.pop_front();
            checks++;
            if (o_rd_key !== e) begin
                errors++;
                $display("FAIL a1_rk%0d: got %h expected %h", idx[k], o_rd_key, e);
            end
        end
    endtask

    task automatic test_aes192();
        int cnt;
        logic [3:0]   idx [2] = '{4'd0, 4'd12};
        logic [127:0] exp [2] = '{128'h8e73b0f7da0e6452c810f32b809079e5,
                                  128'he98ba06f448c773c8ecc720401002202};
        logic [127:0] e;
        do_start(2'b01, c_KEY192);
        wait_done(100, cnt);
        checks++;
        if (cnt !== 46) begin
            errors++;
            $display("FAIL a2_done_latency: got %0d expected 46", cnt);
        end
        checks++;
        if (o_num_rounds !== 4'd12 || o_key_valid !== 1'b1) begin
            errors++;
            $display("FAIL a2_complete: got nr=%0d kv=%b expected 12 1", o_num_rounds, o_key_valid);
        end
        for (int k = 0; k < 2; k++) begin
            i_rd_idx = idx[k];
            rd_q.push_back(exp[k]);
            tick();
            e = rd_q.pop_front();
            checks++;
            if (o_rd_key !== e) begin
                errors++;
                $display("FAIL a2_rk%0d: got %h expected %h", idx[k], o_rd_key, e);
            end
        end
    endtask

    task automatic test_aes256();
        int cnt;
        logic [3:0]   idx [4] = '{4'd1, 4'd2, 4'd14, 4'd15};
        logic [127:0] exp [4] = '{128'h1f352c073b6108d72d9810a30914dff4,
                                  128'h9ba354118e6925afa51a8b5f2067fcde,
                                  128'hfe4890d1e6188d0b046df344706c631e,
                                  128'h0};
        logic [127:0] e;
        do_start(2'b10, c_KEY256);
        wait_done(100, cnt);
        checks++;
        if (cnt !== 52) begin
            errors++;
            $display("FAIL a3_done_latency: got %0d expected 52", cnt);
        end
        checks++;
        if (o_num_rounds !== 4'd14) begin
            errors++;
            $display("FAIL a3_num_rounds: got %0d expected 14", o_num_rounds);
        end
        for (int k = 0; k < 4; k++) begin
            i_rd_idx = idx[k];
            rd_q.push_back(exp[k]);
            tick();
            e = rd_q.pop_front();
            checks++;
            if (o_rd_key !== e) begin
                errors++;
                $display("FAIL a3_rk%0d: got %h expected %h", idx[k], o_rd_key, e);
            end
        end
    endtask

    // Runs after the AES-256 schedule, which must survive the rejected start.
    task automatic test_invalid_len();
        logic [127:0] e;
        do_start(2'b11, c_KEY128);
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_key_valid !== 1'b1) begin
            errors++;
            $display("FAIL inv_err_pulse: got err=%b busy=%b kv=%b expected 1 0 1", o_err, o_busy, o_key_valid);
        end
        tick();
        checks++;
        if (o_err !== 1'b0 || o_busy !== 1'b0 || o_num_rounds !== 4'd14) begin
            errors++;
            $display("FAIL inv_after: got err=%b busy=%b nr=%0d expected 0 0 14", o_err, o_busy, o_num_rounds);
        end
        i_rd_idx = 4'd14;
        rd_q.push_back(128'hfe4890d1e6188d0b046df344706c631e);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (o_rd_key !== e) begin
            errors++;
            $display("FAIL inv_store_kept: got %h expected %h", o_rd_key, e);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        int done_seen;
        logic [127:0] e;
        i_rd_idx = 4'd1;
        do_start(2'b00, c_KEY128);
        for (int k = 0; k < 19; k++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_key_valid !== 1'b0 || o_done !== 1'b0 || o_rd_key !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_state: got busy=%b kv=%b done=%b rd=%h expected 0 0 0 0",
                     o_busy, o_key_valid, o_done, o_rd_key);
        end
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_done) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done: got done_pulses=%0d busy=%b expected 0 0", done_seen, o_busy);
        end
        do_start(2'b00, c_KEY128);
        wait_done(100, cnt);
        checks++;
        if (cnt !== 40) begin
            errors++;
            $display("FAIL rstmid_rerun_latency: got %0d expected 40", cnt);
        end
        i_rd_idx = 4'd10;
        rd_q.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        tick();
        e = rd_q.pop_front();
        checks++;
        if (o_rd_key !== e) begin
            errors++;
            $display("FAIL rstmid_rerun_rk10: got %h expected %h", o_rd_key, e);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        logic [3:0]   idx [3] = '{4'd10, 4'd11, 4'd15};
        logic [127:0] exp [3] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0, 128'h0};
        logic [127:0] e;
        i_key_len = 2'b00;
        i_key     = c_KEY128;
        i_start   = 1'b1;
        tick();
        wait_done(100, cnt);
        checks++;
        if (cnt !== 40) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d expected 40", cnt);
        end
        tick();
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_key_valid !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reaccept: got busy=%b kv=%b done=%b expected 1 0 0", o_busy, o_key_valid, o_done);
        end
        wait_done(100, cnt);
        checks++;
        if (cnt !== 40) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d expected 40", cnt);
        end
        for (int k = 0; k < 3; k++) begin
            i_rd_idx = idx[k];
            rd_q.push_back(exp[k]);
            tick();
            e = rd_q.pop_front();
            checks++;
            if (o_rd_key !== e) begin
                errors++;
                $display("FAIL b2b_rk%0d: got %h expected %h", idx[k], o_rd_key, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_invalid_len();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
